// File: rtl/stage3_ex_mem_queue_if.sv
// Handshake, flush and forwarding bundle between EX, the EX->MEM queue and MEM.
// The master side is the pipeline (EX producer, MEM consumer, hazard unit);
// the slave side is the queue itself.
interface stage3_ex_mem_queue_if #(
    parameter int PAYLOAD_W = 160,
    parameter int XLEN      = 32,
    parameter int RD_W      = 5,
    parameter int DEPTH     = 2
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    // EX side
    logic                 ex_valid;
    logic                 ex_ready;
    logic [PAYLOAD_W-1:0] ex_payload;
    logic                 ex_reg_write;
    logic [RD_W-1:0]      ex_rd;
    logic [XLEN-1:0]      ex_wdata;
    // MEM side
    logic                 mem_valid;
    logic                 mem_ready;
    logic [PAYLOAD_W-1:0] mem_payload;
    logic                 mem_reg_write;
    logic [RD_W-1:0]      mem_rd;
    logic [XLEN-1:0]      mem_wdata;
    // Flush control
    logic                 flush_all;
    logic                 flush_younger;
    // Forwarding queries
    logic [RD_W-1:0]      fwd_rs1;
    logic [RD_W-1:0]      fwd_rs2;
    logic                 fwd_rs1_hit;
    logic [XLEN-1:0]      fwd_rs1_data;
    logic                 fwd_rs2_hit;
    logic [XLEN-1:0]      fwd_rs2_data;
    // Status
    logic [CNT_W-1:0]     occupancy;

    modport master (
        output ex_valid, ex_payload, ex_reg_write, ex_rd, ex_wdata,
        output mem_ready, flush_all, flush_younger, fwd_rs1, fwd_rs2,
        input  ex_ready, mem_valid, mem_payload, mem_reg_write, mem_rd, mem_wdata,
        input  fwd_rs1_hit, fwd_rs1_data, fwd_rs2_hit, fwd_rs2_data, occupancy
    );

    modport slave (
        input  ex_valid, ex_payload, ex_reg_write, ex_rd, ex_wdata,
        input  mem_ready, flush_all, flush_younger, fwd_rs1, fwd_rs2,
        output ex_ready, mem_valid, mem_payload, mem_reg_write, mem_rd, mem_wdata,
        output fwd_rs1_hit, fwd_rs1_data, fwd_rs2_hit, fwd_rs2_data, occupancy
    );
endinterface

// File: rtl/stage3_ex_mem_queue.sv
// Elastic EX->MEM buffer: DEPTH-entry circular queue with valid/ready on both
// sides, full/younger-only flush and two-port youngest-match forwarding.
module stage3_ex_mem_queue #(
    parameter int PAYLOAD_W = 160,
    parameter int XLEN      = 32,
    parameter int RD_W      = 5,
    parameter int DEPTH     = 2
) (
    input  logic                   CLK,
    input  logic                   nRST,
    stage3_ex_mem_queue_if.slave   bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]     head_reg;
    logic [PTR_W-1:0]     tail_reg;
    logic [CNT_W-1:0]     count_reg;

    logic [PAYLOAD_W-1:0] payload_mem [DEPTH];
    logic                 reg_write_mem [DEPTH];
    logic [RD_W-1:0]      rd_mem [DEPTH];
    logic [XLEN-1:0]      wdata_mem [DEPTH];

    logic                 enq;
    logic                 deq;
    logic                 wr_en;

    // Wrap by explicit compare so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign bus.ex_ready  = (count_reg != FULL_CNT);
    assign bus.mem_valid = (count_reg != '0);
    assign enq   = bus.ex_valid & bus.ex_ready;
    assign deq   = bus.mem_valid & bus.mem_ready;
    // Any flush discards the incoming entry.
    assign wr_en = enq & ~bus.flush_all & ~bus.flush_younger;

    assign bus.mem_payload   = payload_mem[head_reg];
    assign bus.mem_reg_write = reg_write_mem[head_reg];
    assign bus.mem_rd        = rd_mem[head_reg];
    assign bus.mem_wdata     = wdata_mem[head_reg];
    assign bus.occupancy     = count_reg;

    // Pointer and count update; flush_all beats flush_younger beats enq/deq.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (bus.flush_all) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else if (bus.flush_younger) begin
            if (count_reg != '0) begin
                tail_reg <= ptr_inc(head_reg);
                if (deq) begin
                    head_reg  <= ptr_inc(head_reg);
                    count_reg <= '0;
                end else begin
                    count_reg <= CNT_W'(1);
                end
            end
        end else begin
            if (enq) tail_reg <= ptr_inc(tail_reg);
            if (deq) head_reg <= ptr_inc(head_reg);
            if (enq && !deq)      count_reg <= count_reg + 1'b1;
            else if (!enq && deq) count_reg <= count_reg - 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Entry storage, written only when the tail points here.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    payload_mem[gi]   <= '0;
                    reg_write_mem[gi] <= 1'b0;
                    rd_mem[gi]        <= '0;
                    wdata_mem[gi]     <= '0;
                end else if (wr_en && (tail_reg == PTR_W'(gi))) begin
                    payload_mem[gi]   <= bus.ex_payload;
                    reg_write_mem[gi] <= bus.ex_reg_write;
                    rd_mem[gi]        <= bus.ex_rd;
                    wdata_mem[gi]     <= bus.ex_wdata;
                end
            end
        end
    endgenerate

    logic [RD_W-1:0] fwd_rs   [2];
    logic            fwd_hit  [2];
    logic [XLEN-1:0] fwd_data [2];

    assign fwd_rs[0] = bus.fwd_rs1;
    assign fwd_rs[1] = bus.fwd_rs2;
    assign bus.fwd_rs1_hit  = fwd_hit[0];
    assign bus.fwd_rs1_data = fwd_data[0];
    assign bus.fwd_rs2_hit  = fwd_hit[1];
    assign bus.fwd_rs2_data = fwd_data[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            // Walk oldest to youngest so the last match (youngest) wins.
            always_comb begin
                logic [PTR_W-1:0] idx;
                fwd_hit[gi]  = 1'b0;
                fwd_data[gi] = '0;
                idx          = head_reg;
                for (int k = 0; k < DEPTH; k++) begin
                    if ((CNT_W'(k) < count_reg) && reg_write_mem[idx] &&
                        (rd_mem[idx] != '0) && (rd_mem[idx] == fwd_rs[gi])) begin
                        fwd_hit[gi]  = 1'b1;
                        fwd_data[gi] = wdata_mem[idx];
                    end
                    idx = ptr_inc(idx);
                end
            end
        end
    endgenerate
endmodule

// File: tb/tb_stage3_ex_mem_queue.sv
// Self-checking bench: one DEPTH=2 and one DEPTH=3 queue driven with the same
// stimulus, each compared every cycle against a queue-based reference model.
module tb_stage3_ex_mem_queue;
    typedef struct {
        logic [159:0] pl;
        logic         rw;
        logic [4:0]   rd;
        logic [31:0]  wd;
    } ent_t;

    logic         CLK;
    logic         nRST;
    logic         ex_valid, mem_ready, flush_all, flush_younger, ex_reg_write;
    logic [159:0] ex_payload;
    logic [4:0]   ex_rd, fwd_rs1, fwd_rs2;
    logic [31:0]  ex_wdata;

    int   n_checks = 0;
    int   n_fail   = 0;
    ent_t q2[$];
    ent_t q3[$];
    ent_t out3[$];
    bit   record3 = 0;

    stage3_ex_mem_queue_if #(.PAYLOAD_W(160), .XLEN(32), .RD_W(5), .DEPTH(2)) i2 ();
    stage3_ex_mem_queue_if #(.PAYLOAD_W(160), .XLEN(32), .RD_W(5), .DEPTH(3)) i3 ();

    assign i2.ex_valid = ex_valid;       assign i3.ex_valid = ex_valid;
    assign i2.ex_payload = ex_payload;   assign i3.ex_payload = ex_payload;
    assign i2.ex_reg_write = ex_reg_write; assign i3.ex_reg_write = ex_reg_write;
    assign i2.ex_rd = ex_rd;             assign i3.ex_rd = ex_rd;
    assign i2.ex_wdata = ex_wdata;       assign i3.ex_wdata = ex_wdata;
    assign i2.mem_ready = mem_ready;     assign i3.mem_ready = mem_ready;
    assign i2.flush_all = flush_all;     assign i3.flush_all = flush_all;
    assign i2.flush_younger = flush_younger; assign i3.flush_younger = flush_younger;
    assign i2.fwd_rs1 = fwd_rs1;         assign i3.fwd_rs1 = fwd_rs1;
    assign i2.fwd_rs2 = fwd_rs2;         assign i3.fwd_rs2 = fwd_rs2;

    stage3_ex_mem_queue #(.PAYLOAD_W(160), .XLEN(32), .RD_W(5), .DEPTH(2)) dut2 (
        .CLK(CLK), .nRST(nRST), .bus(i2.slave));
    stage3_ex_mem_queue #(.PAYLOAD_W(160), .XLEN(32), .RD_W(5), .DEPTH(3)) dut3 (
        .CLK(CLK), .nRST(nRST), .bus(i3.slave));

    initial begin
        CLK = 0;
        forever #5 CLK = ~CLK;
    end

    // Compare one DUT's combinational view against the model queue.
    task automatic check_dut(input int d, input string tag);
        ent_t q[$];
        int dep, occ;
        logic mv, er, h1, h2, rw, eh1, eh2;
        logic [159:0] pl;
        logic [4:0] rd;
        logic [31:0] wd, f1, f2, ef1, ef2;
        if (d == 0) begin
            q = q2; dep = 2; mv = i2.mem_valid; er = i2.ex_ready; occ = int'(i2.occupancy);
            pl = i2.mem_payload; rw = i2.mem_reg_write; rd = i2.mem_rd; wd = i2.mem_wdata;
            h1 = i2.fwd_rs1_hit; f1 = i2.fwd_rs1_data; h2 = i2.fwd_rs2_hit; f2 = i2.fwd_rs2_data;
        end else begin
            q = q3; dep = 3; mv = i3.mem_valid; er = i3.ex_ready; occ = int'(i3.occupancy);
            pl = i3.mem_payload; rw = i3.mem_reg_write; rd = i3.mem_rd; wd = i3.mem_wdata;
            h1 = i3.fwd_rs1_hit; f1 = i3.fwd_rs1_data; h2 = i3.fwd_rs2_hit; f2 = i3.fwd_rs2_data;
        end
        n_checks++;
        if (mv !== (q.size() != 0)) begin
            n_fail++; $display("FAIL %s/dut%0d mem_valid: got %b expected %b", tag, d, mv, q.size() != 0);
        end
        n_checks++;
        if (er !== (q.size() != dep)) begin
            n_fail++; $display("FAIL %s/dut%0d ex_ready: got %b expected %b", tag, d, er, q.size() != dep);
        end
        n_checks++;
        if (occ != q.size()) begin
            n_fail++; $display("FAIL %s/dut%0d occupancy: got %0d expected %0d", tag, d, occ, q.size());
        end
        if (q.size() > 0) begin
            n_checks++;
            if (pl !== q[0].pl || rw !== q[0].rw || rd !== q[0].rd || wd !== q[0].wd) begin
                n_fail++;
                $display("FAIL %s/dut%0d head: got rw=%b rd=%0d wd=%h pl=%h expected rw=%b rd=%0d wd=%h pl=%h",
                         tag, d, rw, rd, wd, pl, q[0].rw, q[0].rd, q[0].wd, q[0].pl);
            end
        end
        // Youngest match: scan from the tail end backwards.
        eh1 = 0; ef1 = 0; eh2 = 0; ef2 = 0;
        for (int i = q.size() - 1; i >= 0; i--)
            if (!eh1 && fwd_rs1 != 0 && q[i].rw && q[i].rd == fwd_rs1) begin eh1 = 1; ef1 = q[i].wd; end
        for (int i = q.size() - 1; i >= 0; i--)
            if (!eh2 && fwd_rs2 != 0 && q[i].rw && q[i].rd == fwd_rs2) begin eh2 = 1; ef2 = q[i].wd; end
        n_checks++;
        if (h1 !== eh1 || f1 !== ef1) begin
            n_fail++; $display("FAIL %s/dut%0d fwd1 rs=%0d: got %b/%h expected %b/%h", tag, d, fwd_rs1, h1, f1, eh1, ef1);
        end
        n_checks++;
        if (h2 !== eh2 || f2 !== ef2) begin
            n_fail++; $display("FAIL %s/dut%0d fwd2 rs=%0d: got %b/%h expected %b/%h", tag, d, fwd_rs2, h2, f2, eh2, ef2);
        end
    endtask

    // One clock cycle: check, log MEM consumption, clock edge, advance models.
    task automatic step(input string tag);
        #3;
        check_dut(0, tag);
        check_dut(1, tag);
        $display("%0t %s: ex_v=%b mem_r=%b fa=%b fy=%b occ2=%0d occ3=%0d", $time, tag,
                 ex_valid, mem_ready, flush_all, flush_younger, q2.size(), q3.size());
        if (record3 && i3.mem_valid && mem_ready && !flush_all)
            out3.push_back('{i3.mem_payload, i3.mem_reg_write, i3.mem_rd, i3.mem_wdata});
        @(posedge CLK);
        for (int d = 0; d < 2; d++) begin
            ent_t q[$];
            ent_t n, h;
            int dep;
            bit enq, deq;
            if (d == 0) begin q = q2; dep = 2; end else begin q = q3; dep = 3; end
            n = '{ex_payload, ex_reg_write, ex_rd, ex_wdata};
            enq = ex_valid && (q.size() < dep);
            deq = mem_ready && (q.size() > 0);
            if (flush_all) q.delete();
            else if (flush_younger) begin
                if (q.size() > 0) begin
                    h = q[0];
                    q.delete();
                    if (!deq) q.push_back(h);
                end
            end else begin
                if (deq) void'(q.pop_front());
                if (enq) q.push_back(n);
            end
            if (d == 0) q2 = q; else q3 = q;
        end
        #1;
    endtask

    task automatic set_entry();
        ex_payload   = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        ex_reg_write = ($urandom_range(0, 3) != 0);
        ex_rd        = 5'($urandom_range(0, 3));
        ex_wdata     = $urandom();
    endtask

    task automatic drain();
        ex_valid = 0; flush_all = 0; flush_younger = 0; mem_ready = 1;
        repeat (4) step("drain");
        mem_ready = 0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (i2.mem_valid !== 0 || i2.ex_ready !== 1 || i2.occupancy !== 0 || i2.mem_payload !== 0 ||
            i2.mem_wdata !== 0 || i2.fwd_rs1_hit !== 0 || i2.fwd_rs2_hit !== 0) begin
            n_fail++; $display("FAIL reset/dut2: got mv=%b er=%b occ=%0d", i2.mem_valid, i2.ex_ready, i2.occupancy);
        end
        n_checks++;
        if (i3.mem_valid !== 0 || i3.ex_ready !== 1 || i3.occupancy !== 0 || i3.mem_payload !== 0 ||
            i3.mem_rd !== 0 || i3.fwd_rs1_data !== 0 || i3.fwd_rs2_data !== 0) begin
            n_fail++; $display("FAIL reset/dut3: got mv=%b er=%b occ=%0d", i3.mem_valid, i3.ex_ready, i3.occupancy);
        end
    endtask

    task automatic test_backpressure();
        logic [159:0] a, b;
        drain();
        ex_valid = 1; set_entry(); a = ex_payload; step("bp_a");
        set_entry(); b = ex_payload; step("bp_b");
        ex_valid = 0; step("bp_hold");
        n_checks++;
        if (i2.ex_ready !== 0 || i2.mem_payload !== a) begin
            n_fail++; $display("FAIL bp_full: got ready=%b pl=%h expected ready=0 pl=%h", i2.ex_ready, i2.mem_payload, a);
        end
        mem_ready = 1; step("bp_pop"); mem_ready = 0;
        n_checks++;
        if (i2.mem_payload !== b || i2.occupancy !== 1) begin
            n_fail++; $display("FAIL bp_pop: got occ=%0d pl=%h expected occ=1 pl=%h", i2.occupancy, i2.mem_payload, b);
        end
    endtask

    task automatic test_wrap();
        logic [159:0] sent[$];
        int cyc = 0;
        drain();
        out3.delete(); record3 = 1;
        while (sent.size() < 7 && cyc < 60) begin
            ex_valid = 1; set_entry(); mem_ready = cyc[0];
            if (i3.ex_ready) sent.push_back(ex_payload);
            step("wrap");
            cyc++;
        end
        ex_valid = 0; mem_ready = 1;
        for (int i = 0; i < 8 && i3.mem_valid; i++) step("wrap_drain");
        record3 = 0; mem_ready = 0;
        n_checks++;
        if (out3.size() != 7 || sent.size() != 7) begin
            n_fail++; $display("FAIL wrap_count: got %0d out of %0d sent, expected 7", out3.size(), sent.size());
        end
        for (int i = 0; i < out3.size() && i < sent.size(); i++) begin
            n_checks++;
            if (out3[i].pl !== sent[i]) begin
                n_fail++; $display("FAIL wrap_order[%0d]: got %h expected %h", i, out3[i].pl, sent[i]);
            end
        end
    endtask

    task automatic test_flush();
        logic [159:0] a;
        int exp_occ;
        for (int mode = 0; mode < 3; mode++) begin
            drain();
            ex_valid = 1; set_entry(); a = ex_payload; step("fl_fill");
            set_entry(); step("fl_fill");
            set_entry(); flush_younger = 1; flush_all = (mode == 2); mem_ready = (mode != 0);
            step("fl_do");
            flush_younger = 0; flush_all = 0; ex_valid = 0; mem_ready = 0;
            exp_occ = (mode == 0) ? 1 : 0;
            n_checks++;
            if (int'(i2.occupancy) != exp_occ || int'(i3.occupancy) != exp_occ) begin
                n_fail++; $display("FAIL flush_mode%0d: got occ2=%0d occ3=%0d expected %0d", mode, i2.occupancy, i3.occupancy, exp_occ);
            end
            if (mode == 0) begin
                n_checks++;
                if (i2.mem_payload !== a || i3.mem_payload !== a) begin
                    n_fail++; $display("FAIL flush_head: got %h expected %h", i2.mem_payload, a);
                end
            end
        end
        drain();
        ex_valid = 1; set_entry(); flush_younger = 1; step("fl_empty");
        flush_younger = 0; ex_valid = 0;
        n_checks++;
        if (i2.occupancy !== 0 || i3.occupancy !== 0) begin
            n_fail++; $display("FAIL flush_empty: got occ2=%0d occ3=%0d expected 0", i2.occupancy, i3.occupancy);
        end
    endtask

    task automatic test_forward();
        drain();
        ex_valid = 1; ex_reg_write = 1;
        ex_payload = 160'h1; ex_rd = 5; ex_wdata = 32'h11; step("fw_a");
        ex_payload = 160'h2; ex_rd = 5; ex_wdata = 32'h22; step("fw_b");
        ex_payload = 160'h3; ex_rd = 0; ex_wdata = 32'h33; step("fw_c");
        ex_rd = 5; ex_wdata = 32'h99;
        fwd_rs1 = 5; fwd_rs2 = 0;
        #1;
        n_checks++;
        if (i2.fwd_rs1_hit !== 1 || i2.fwd_rs1_data !== 32'h22 || i3.fwd_rs1_hit !== 1 || i3.fwd_rs1_data !== 32'h22) begin
            n_fail++; $display("FAIL fwd_rs1: got %b/%h and %b/%h expected 1/00000022",
                               i2.fwd_rs1_hit, i2.fwd_rs1_data, i3.fwd_rs1_hit, i3.fwd_rs1_data);
        end
        n_checks++;
        if (i2.fwd_rs2_hit !== 0 || i2.fwd_rs2_data !== 0 || i3.fwd_rs2_hit !== 0 || i3.fwd_rs2_data !== 0) begin
            n_fail++; $display("FAIL fwd_rs2_zero: got %b/%h and %b/%h expected 0/00000000",
                               i2.fwd_rs2_hit, i2.fwd_rs2_data, i3.fwd_rs2_hit, i3.fwd_rs2_data);
        end
        step("fw_query");
        ex_valid = 0; fwd_rs1 = 0;
    endtask

    task automatic test_back_to_back();
        drain();
        ex_valid = 1; set_entry(); step("b2b_fill");
        mem_ready = 1;
        for (int i = 0; i < 10; i++) begin
            set_entry(); step("b2b");
            n_checks++;
            if (i2.occupancy !== 1 || i3.occupancy !== 1) begin
                n_fail++; $display("FAIL b2b_occ[%0d]: got %0d/%0d expected 1", i, i2.occupancy, i3.occupancy);
            end
        end
        ex_valid = 0; mem_ready = 0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ex_valid = ($urandom_range(0, 3) != 0);
            mem_ready = $urandom_range(0, 1);
            flush_all = ($urandom_range(0, 31) == 0);
            flush_younger = ($urandom_range(0, 15) == 0);
            fwd_rs1 = 5'($urandom_range(0, 3));
            fwd_rs2 = 5'($urandom_range(0, 3));
            set_entry();
            step("rand");
        end
        flush_all = 0; flush_younger = 0;
    endtask

    task automatic test_reset_mid();
        drain();
        ex_valid = 1; set_entry(); step("rm_fill"); set_entry(); step("rm_fill");
        ex_valid = 0;
        nRST = 0;
        #1;
        n_checks++;
        if (i2.mem_valid !== 0 || i2.ex_ready !== 1 || i2.occupancy !== 0 ||
            i3.mem_valid !== 0 || i3.ex_ready !== 1 || i3.occupancy !== 0) begin
            n_fail++; $display("FAIL reset_mid: got mv=%b er=%b occ=%0d expected 0/1/0", i2.mem_valid, i2.ex_ready, i2.occupancy);
        end
        q2.delete(); q3.delete();
        #1 nRST = 1;
        step("rm_after");
    endtask

    initial begin
        nRST = 0; ex_valid = 0; mem_ready = 0; flush_all = 0; flush_younger = 0;
        ex_payload = '0; ex_reg_write = 0; ex_rd = 0; ex_wdata = 0; fwd_rs1 = 5; fwd_rs2 = 0;
        #1;
        test_reset();
        @(posedge CLK); #1;
        nRST = 1;
        test_backpressure();
        test_wrap();
        test_flush();
        test_forward();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
